lane_mode_controller: RTL and testbench

Sequences run-time changes of the lane mode (single-lane vs dual-lane) that selects the clock divider ratio (/8 single-lane, /2 dual-lane).
Accepts a mode-change request and asks the lane datapath to drain. It then holds the divider and switches the `single_lane` select. After a settle period it releases the datapath and reports completion.
Sits between the link management logic (requester) and the clock divider and lane datapath (controlled resources), all in the `clk_in` domain.

---
 rtl/lane_mode_controller.sv | 232 +++++++++++++++++++++++
 tb/tb_lane_mode_controller.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_mode_controller.sv
// lane_mode_controller
// Sequences a run-time switch between single-lane (/8) and dual-lane (/2)
// clock divider ratios: drain the lane datapath, freeze the divider, flip
// the mode select, let the divider settle, then release the datapath.
// Every output is a register loaded from the next-state decode, so each
// output lines up exactly with the state it belongs to.

module lane_mode_controller #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned DRAIN_TIMEOUT = 256
) (
    input  logic clk_in,
    input  logic rst,
    input  logic req_valid,
    input  logic req_single_lane,
    output logic req_ready,
    output logic drain_req,
    input  logic drain_done,
    output logic div_hold,
    output logic single_lane,
    output logic busy,
    output logic done_pulse,
    output logic timeout_err
);

    // One shared counter is reused by DRAIN, HOLD and SETTLE; it is sized
    // for the longest of those dwell times.
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > DRAIN_TIMEOUT) ? SETTLE_CYCLES : DRAIN_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // Terminal counts: the counter holds the number of completed cycles in
    // the current state, so the last cycle of a state sees N-1.
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_HOLD   = 3'd2,
        ST_SWITCH = 3'd3,
        ST_SETTLE = 3'd4,
        ST_DONE   = 3'd5,
        ST_ABORT  = 3'd6
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_next_s;
    logic              target_r;
    logic              target_next_s;
    logic              single_lane_r;
    logic              single_lane_next_s;

    logic              ready_r;
    logic              drain_req_r;
    logic              div_hold_r;
    logic              busy_r;
    logic              done_pulse_r;
    logic              timeout_err_r;

    logic              ready_next_s;
    logic              drain_req_next_s;
    logic              div_hold_next_s;
    logic              busy_next_s;
    logic              done_pulse_next_s;
    logic              timeout_err_next_s;

    logic              accept_s;

    // A request is taken only from IDLE and never while reset is asserted.
    assign accept_s = req_valid & ready_r & ~rst;

    // Next-state, counter, target and mode-select decode.
    always_comb begin
        state_next_s       = state_r;
        target_next_s      = target_r;
        single_lane_next_s = single_lane_r;
        cnt_next_s         = cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    target_next_s = req_single_lane;
                    if (req_single_lane == single_lane_r) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_DRAIN;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // A drained datapath wins over a timeout in the same cycle.
                if (drain_done) begin
                    state_next_s = ST_HOLD;
                end else if (cnt_r == DRAIN_LAST) begin
                    state_next_s = ST_ABORT;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (cnt_r == HOLD_LAST) begin
                    state_next_s = ST_SWITCH;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            ST_SWITCH: begin
                // Mode select flips while the divider is still frozen.
                single_lane_next_s = target_r;
                state_next_s       = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_r == SETTLE_LAST) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            ST_ABORT: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        // Counter clears on every state entry and only advances in the
        // timed states, whose terminal compare always leaves before a wrap.
        if (state_next_s != state_r) begin
            cnt_next_s = CNT_ZERO;
        end else if ((state_r == ST_DRAIN) || (state_r == ST_HOLD) || (state_r == ST_SETTLE)) begin
            cnt_next_s = cnt_r + CNT_ONE;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Moore output decode from the state being entered next cycle.
    always_comb begin
        ready_next_s       = 1'b0;
        drain_req_next_s   = 1'b0;
        div_hold_next_s    = 1'b0;
        busy_next_s        = 1'b1;
        done_pulse_next_s  = 1'b0;
        timeout_err_next_s = 1'b0;

        case (state_next_s)
            ST_IDLE: begin
                ready_next_s = 1'b1;
                busy_next_s  = 1'b0;
            end
            ST_DRAIN: begin
                drain_req_next_s = 1'b1;
            end
            ST_HOLD: begin
                drain_req_next_s = 1'b1;
                div_hold_next_s  = 1'b1;
            end
            ST_SWITCH: begin
                drain_req_next_s = 1'b1;
                div_hold_next_s  = 1'b1;
            end
            ST_SETTLE: begin
                drain_req_next_s = 1'b1;
            end
            ST_DONE: begin
                done_pulse_next_s = 1'b1;
            end
            ST_ABORT: begin
                timeout_err_next_s = 1'b1;
            end
            default: begin
                busy_next_s = 1'b1;
            end
        endcase
    end

    // State, counter, target and mode-select registers.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            target_r      <= 1'b0;
            single_lane_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            cnt_r         <= cnt_next_s;
            target_r      <= target_next_s;
            single_lane_r <= single_lane_next_s;
        end
    end

    // Registered outputs; reset lands in IDLE with everything deasserted.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            ready_r       <= 1'b1;
            drain_req_r   <= 1'b0;
            div_hold_r    <= 1'b0;
            busy_r        <= 1'b0;
            done_pulse_r  <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            ready_r       <= ready_next_s;
            drain_req_r   <= drain_req_next_s;
            div_hold_r    <= div_hold_next_s;
            busy_r        <= busy_next_s;
            done_pulse_r  <= done_pulse_next_s;
            timeout_err_r <= timeout_err_next_s;
        end
    end

    // req_ready is masked by rst so the requester never sees a handshake
    // opportunity while the block is being reset.
    assign req_ready   = ready_r & ~rst;
    assign drain_req   = drain_req_r;
    assign div_hold    = div_hold_r;
    assign single_lane = single_lane_r;
    assign busy        = busy_r;
    assign done_pulse  = done_pulse_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_lane_mode_controller.sv
// Directed bench for lane_mode_controller with default parameters.
// Output vector order: {drain_req, div_hold, single_lane, busy,
//                       done_pulse, timeout_err, req_ready}

module tb_lane_mode_controller;

    logic clk_in;
    logic rst;
    logic req_valid;
    logic req_single_lane;
    logic req_ready;
    logic drain_req;
    logic drain_done;
    logic div_hold;
    logic single_lane;
    logic busy;
    logic done_pulse;
    logic timeout_err;

    int n_cmp;
    int n_bad;

    lane_mode_controller #(
        .SETTLE_CYCLES(16),
        .DRAIN_TIMEOUT(256)
    ) dut (
        .clk_in         (clk_in),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_single_lane(req_single_lane),
        .req_ready      (req_ready),
        .drain_req      (drain_req),
        .drain_done     (drain_done),
        .div_hold       (div_hold),
        .single_lane    (single_lane),
        .busy           (busy),
        .done_pulse     (done_pulse),
        .timeout_err    (timeout_err)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [6:0] outs();
        return {drain_req, div_hold, single_lane, busy, done_pulse, timeout_err, req_ready};
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] exp_v;
        rst = 1'b1;
        tick();
        tick();
        exp_v = 7'b0000000;
        n_cmp++;
        if (outs() !== exp_v) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want %b", outs(), exp_v);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_same_mode();
        logic [6:0] exp_v;
        req_valid       = 1'b1;
        req_single_lane = 1'b0;
        tick();
        req_valid = 1'b0;
        exp_v = 7'b0001100;
        n_cmp++;
        if (outs() !== exp_v) begin
            n_bad++;
            $display("FAIL same_mode_c1: got %b want %b", outs(), exp_v);
        end
        tick();
        exp_v = 7'b0000001;
        n_cmp++;
        if (outs() !== exp_v) begin
            n_bad++;
            $display("FAIL same_mode_c2: got %b want %b", outs(), exp_v);
        end
    endtask

    task automatic test_switch_single();
        logic [6:0] exp_v;
        drain_done      = 1'b1;
        req_valid       = 1'b1;
        req_single_lane = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            req_valid = 1'b0;
            exp_v[6] = (c <= 20);
            exp_v[5] = (c >= 2) && (c <= 4);
            exp_v[4] = (c >= 5);
            exp_v[3] = (c <= 21);
            exp_v[2] = (c == 21);
            exp_v[1] = 1'b0;
            exp_v[0] = (c == 22);
            n_cmp++;
            if (outs() !== exp_v) begin
                n_bad++;
                $display("FAIL switch_single c%0d: got %b want %b", c, outs(), exp_v);
            end
        end
    endtask

    task automatic test_drain_late();
        logic [6:0] exp_v;
        drain_done      = 1'b0;
        req_valid       = 1'b1;
        req_single_lane = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            tick();
            req_valid = 1'b0;
            if (c == 10) drain_done = 1'b1;
            exp_v[6] = (c <= 29);
            exp_v[5] = (c >= 11) && (c <= 13);
            exp_v[4] = (c < 14);
            exp_v[3] = (c <= 30);
            exp_v[2] = (c == 30);
            exp_v[1] = 1'b0;
            exp_v[0] = (c == 31);
            n_cmp++;
            if (outs() !== exp_v) begin
                n_bad++;
                $display("FAIL drain_late c%0d: got %b want %b", c, outs(), exp_v);
            end
        end
        drain_done = 1'b0;
    endtask

    task automatic test_timeout();
        logic [6:0] exp_v;
        // drain_done pulses only while IDLE; it must not count.
        drain_done      = 1'b1;
        req_valid       = 1'b1;
        req_single_lane = 1'b1;
        for (int c = 1; c <= 258; c++) begin
            tick();
            req_valid  = 1'b0;
            drain_done = 1'b0;
            exp_v[6] = (c <= 256);
            exp_v[5] = 1'b0;
            exp_v[4] = 1'b0;
            exp_v[3] = (c <= 257);
            exp_v[2] = 1'b0;
            exp_v[1] = (c == 257);
            exp_v[0] = (c == 258);
            n_cmp++;
            if (outs() !== exp_v) begin
                n_bad++;
                $display("FAIL timeout c%0d: got %b want %b", c, outs(), exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] exp_v;
        bit         seen;
        drain_done      = 1'b1;
        req_valid       = 1'b1;
        req_single_lane = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            req_valid = 1'b0;
        end
        exp_v = 7'b1011000;
        n_cmp++;
        if (outs() !== exp_v) begin
            n_bad++;
            $display("FAIL reset_mid_settle: got %b want %b", outs(), exp_v);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_ready_in_rst: got %b want 0", req_ready);
        end
        tick();
        exp_v = 7'b0000000;
        n_cmp++;
        if (outs() !== exp_v) begin
            n_bad++;
            $display("FAIL reset_mid_after: got %b want %b", outs(), exp_v);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_ready: got %b want 1", req_ready);
        end
        req_valid       = 1'b1;
        req_single_lane = 1'b1;
        tick();
        req_valid = 1'b0;
        exp_v = 7'b1001000;
        n_cmp++;
        if (outs() !== exp_v) begin
            n_bad++;
            $display("FAIL reset_mid_reaccept: got %b want %b", outs(), exp_v);
        end
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (done_pulse === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_done: got %b want 1 within 40 cycles", seen);
        end
        tick();
        exp_v = 7'b0010001;
        n_cmp++;
        if (outs() !== exp_v) begin
            n_bad++;
            $display("FAIL reset_mid_final: got %b want %b", outs(), exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_v;
        // single_lane is 1 here; request dual-lane, then keep spamming.
        drain_done      = 1'b1;
        req_valid       = 1'b1;
        req_single_lane = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_ready_c0: got %b want 1", req_ready);
        end
        for (int c = 1; c <= 21; c++) begin
            tick();
            n_cmp++;
            if ({req_ready, busy} !== 2'b01) begin
                n_bad++;
                $display("FAIL b2b_busy c%0d: got ready,busy=%b want 01", c, {req_ready, busy});
            end
            if (c == 5) begin
                n_cmp++;
                if (single_lane !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_mode_c5: got %b want 0", single_lane);
                end
            end
            if (c == 21) begin
                n_cmp++;
                if (done_pulse !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_done_c21: got %b want 1", done_pulse);
                end
                req_valid = 1'b0;
            end else begin
                req_single_lane = ~c[0];
            end
        end
        tick();
        exp_v = 7'b0000001;
        n_cmp++;
        if (outs() !== exp_v) begin
            n_bad++;
            $display("FAIL b2b_idle: got %b want %b", outs(), exp_v);
        end
        tick();
        n_cmp++;
        if (outs() !== exp_v) begin
            n_bad++;
            $display("FAIL b2b_no_requeue: got %b want %b", outs(), exp_v);
        end
    endtask

    initial begin
        n_cmp           = 0;
        n_bad           = 0;
        rst             = 1'b1;
        req_valid       = 1'b0;
        req_single_lane = 1'b0;
        drain_done      = 1'b0;
        test_reset();
        test_same_mode();
        test_switch_single();
        test_drain_late();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
